// File: rtl/cic_pkg.sv
// Shared helpers for the CIC decimator: ceil-log2 and accumulator width derivation.
package cic_pkg;

  localparam int MaxOrder = 6;

  function automatic int clog2(input int value);
    int r = 0;
    while ((longint'(1) << r) < longint'(value)) r++;
    return r;
  endfunction

  function automatic bit is_pow2(input int value);
    return (value > 0) && ((value & (value - 1)) == 0);
  endfunction

  // Bit growth of an ORDER-stage CIC is ORDER*log2(DECIM) over the input width.
  function automatic int acc_width(input int in_w, input int order, input int decim);
    return in_w + order * clog2(decim);
  endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One registered CIC comb stage: y = x - x_prev, modulo 2^W.
module cic_comb_stage #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  logic [W-1:0] r_prev;
  logic [W-1:0] r_data;
  logic         r_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prev  <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_data <= in_data - r_prev;
        r_prev <= in_data;
      end
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_data;

endmodule

// File: rtl/cic_decimator.sv
// CIC decimator: ORDER integrators at the input rate, decimate by DECIM, ORDER pipelined combs,
// and a single-entry output register with overrun detection.
module cic_decimator
  import cic_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int ORDER = 3,
  parameter int DECIM = 64,
  parameter int OUT_W = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             overrun,
  input  logic             clr_overrun
);

  localparam int ACC_W = acc_width(IN_W, ORDER, DECIM);
  localparam int CNT_W = clog2(DECIM);

  if (IN_W < 1) begin : g_bad_in_w
    $error("cic_decimator: IN_W must be at least 1");
  end
  if (ORDER < 1 || ORDER > MaxOrder) begin : g_bad_order
    $error("cic_decimator: ORDER must be in 1..6");
  end
  if (DECIM < 2 || !is_pow2(DECIM)) begin : g_bad_decim
    $error("cic_decimator: DECIM must be a power of two, at least 2");
  end
  if (OUT_W < 1 || OUT_W > ACC_W) begin : g_bad_out_w
    $error("cic_decimator: OUT_W must be in 1..ACC_W");
  end

  logic [ACC_W-1:0] r_integ     [ORDER];
  logic [ACC_W-1:0] w_integ_nxt [ORDER];
  logic [ACC_W-1:0] w_in_ext;
  logic [CNT_W-1:0] r_cnt;
  logic             w_tick;

  assign w_in_ext = {{(ACC_W - IN_W){in_data[IN_W-1]}}, in_data};
  assign w_tick   = in_valid && (r_cnt == CNT_W'(DECIM - 1));

  // Each integrator adds its predecessor's registered value, keeping adders off a long chain.
  for (genvar k = 0; k < ORDER; k++) begin : g_integ
    if (k == 0) begin : g_first
      assign w_integ_nxt[k] = r_integ[k] + w_in_ext;
    end else begin : g_rest
      assign w_integ_nxt[k] = r_integ[k] + r_integ[k-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < ORDER; k++) r_integ[k] <= '0;
      r_cnt <= '0;
    end else if (in_valid) begin
      for (int k = 0; k < ORDER; k++) r_integ[k] <= w_integ_nxt[k];
      r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
    end
  end

  logic [ACC_W-1:0] w_comb_data [ORDER+1];
  logic             w_comb_vld  [ORDER+1];

  assign w_comb_data[0] = w_integ_nxt[ORDER-1];
  assign w_comb_vld[0]  = w_tick;

  for (genvar k = 0; k < ORDER; k++) begin : g_comb
    cic_comb_stage #(
      .W (ACC_W)
    ) u_comb (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (w_comb_vld[k]),
      .in_data   (w_comb_data[k]),
      .out_valid (w_comb_vld[k+1]),
      .out_data  (w_comb_data[k+1])
    );
  end

  logic             w_load;
  logic             w_ovr_event;
  logic [OUT_W-1:0] r_out_data;
  logic             r_out_valid;
  logic             r_overrun;
  logic             w_unused_lsbs;

  assign w_load        = w_comb_vld[ORDER];
  assign w_ovr_event   = w_load && r_out_valid && !out_ready;
  assign w_unused_lsbs = ^w_comb_data[ORDER];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_load) begin
        r_out_data  <= w_comb_data[ORDER][ACC_W-1 -: OUT_W];
        r_out_valid <= 1'b1;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
      // A new loss in the same cycle as a clear keeps the flag set.
      if (w_ovr_event) begin
        r_overrun <= 1'b1;
      end else if (clr_overrun) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_cic_decimator.sv
// Bench for cic_decimator: closed-form CIC model plus directed literal checks on two output widths.
module tb_cic_decimator;

  localparam int IN_W  = 8;
  localparam int ORDER = 2;
  localparam int DECIM = 4;
  localparam int ACC_W = 12;
  localparam int OW_A  = 12;
  localparam int OW_B  = 8;

  logic            clk;
  logic            reset = 1'b0;
  logic            in_valid = 1'b0;
  logic [IN_W-1:0] in_data = '0;
  logic            out_ready = 1'b0;
  logic            clr_overrun = 1'b0;
  logic            va, vb, ova, ovb;
  logic [OW_A-1:0] da;
  logic [OW_B-1:0] db;

  int tests = 0;
  int fails = 0;

  cic_decimator #(.IN_W(IN_W), .ORDER(ORDER), .DECIM(DECIM), .OUT_W(OW_A)) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .out_valid(va),
    .out_ready(out_ready), .out_data(da), .overrun(ova), .clr_overrun(clr_overrun)
  );

  cic_decimator #(.IN_W(IN_W), .ORDER(ORDER), .DECIM(DECIM), .OUT_W(OW_B)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .out_valid(vb),
    .out_ready(out_ready), .out_data(db), .overrun(ovb), .clr_overrun(clr_overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Model: integrator k after n samples is sum_j C(n-j, k-1) * x_j; the comb section is the
  // ORDER-th backward difference of the decimated snapshots, taken modulo 2^ACC_W.
  typedef struct {
    longint           due;
    logic [ACC_W-1:0] val;
  } pend_t;

  int               hist[$];
  longint           snaps[$];
  pend_t            pend[$];
  longint           edge_n = 0;
  bit               m_valid = 0;
  bit               m_ovr = 0;
  bit               m_loaded = 0;
  logic [ACC_W-1:0] m_acc = '0;

  function automatic longint binom(input int n, input int k);
    longint r = 1;
    if (k < 0 || k > n) return 0;
    for (int i = 1; i <= k; i++) r = r * (n - k + i) / i;
    return r;
  endfunction

  task automatic model_step();
    bit     load;
    bit     ev;
    longint s;
    longint r;
    int     n;
    int     m;
    if (reset) begin
      hist.delete();
      snaps.delete();
      pend.delete();
      edge_n = 0;
      m_valid = 0;
      m_ovr = 0;
      m_loaded = 0;
      m_acc = '0;
      return;
    end
    edge_n++;
    load = 0;
    if (pend.size() > 0 && pend[0].due == edge_n) begin
      load = 1;
      m_acc = pend[0].val;
      void'(pend.pop_front());
    end
    ev = load && m_valid && !out_ready;
    if (load) m_valid = 1;
    else if (m_valid && out_ready) m_valid = 0;
    if (ev) m_ovr = 1;
    else if (clr_overrun) m_ovr = 0;
    m_loaded = load;
    if (in_valid) begin
      hist.push_back(int'($signed(in_data)));
      n = hist.size();
      if (n % DECIM == 0) begin
        s = 0;
        for (int j = 1; j <= n; j++) s += binom(n - j, ORDER - 1) * hist[j-1];
        snaps.push_back(s);
        m = snaps.size();
        r = 0;
        for (int i = 0; i <= ORDER; i++) begin
          if (m - 1 - i >= 0) r += ((i % 2) ? -1 : 1) * binom(ORDER, i) * snaps[m-1-i];
        end
        pend.push_back('{due: edge_n + ORDER, val: r[ACC_W-1:0]});
      end
    end
  endtask

  initial forever begin
    @(posedge clk or posedge reset);
    model_step();
  end

  int got_a[$];
  int got_b[$];
  int mod_a[$];

  initial forever begin
    logic [OW_A-1:0] exp_a;
    logic [OW_B-1:0] exp_b;
    @(negedge clk);
    exp_a = m_acc[ACC_W-1 -: OW_A];
    exp_b = m_acc[ACC_W-1 -: OW_B];
    check("out_valid_a", va, m_valid);
    check("out_valid_b", vb, m_valid);
    check("overrun_a", ova, m_ovr);
    check("overrun_b", ovb, m_ovr);
    if (m_valid) begin
      check("out_data_a", da, exp_a);
      check("out_data_b", db, exp_b);
    end
    if (m_loaded) begin
      got_a.push_back(int'($signed(da)));
      got_b.push_back(int'($signed(db)));
      mod_a.push_back(int'($signed(exp_a)));
    end
  end

  task automatic cycle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    clr_overrun = 1'b0;
    cycle(2);
    reset = 1'b0;
    cycle(1);
    got_a.delete();
    got_b.delete();
    mod_a.delete();
  endtask

  task automatic run_held(input int value, input int n);
    in_data = IN_W'(value);
    in_valid = 1'b1;
    cycle(n);
    in_valid = 1'b0;
    cycle(ORDER + 4);
  endtask

  // Expected settled sequence for a DC input of 1: first result 6, then 16 (gain DECIM^ORDER).
  task automatic check_dc_seq(input string name);
    check({name, "_count"}, got_a.size(), 6);
    for (int k = 0; k < got_a.size(); k++) check({name, "_a"}, got_a[k], (k == 0) ? 6 : 16);
    for (int k = 0; k < got_b.size(); k++) check({name, "_b"}, got_b[k], (k == 0) ? 0 : 1);
  endtask

  initial begin
    int hi;
    int w;
    #1 reset = 1'b1;
    @(negedge clk);
    check("reset_out_valid", va, 0);
    check("reset_out_data", da, 0);
    check("reset_overrun", ova, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    cycle(1);

    // DC gain, continuous input
    out_ready = 1'b1;
    run_held(1, 24);
    check_dc_seq("dc");
    if (mod_a.size() > 2) check("model_dc_pin", mod_a[2], 16);

    // Full-scale negative input
    do_reset();
    run_held(-128, 24);
    check("neg_count", got_a.size(), 6);
    for (int k = 0; k < got_a.size(); k++) check("neg_a", got_a[k], (k == 0) ? -768 : -2048);
    if (got_b.size() > 0) check("neg_last_b", got_b[got_b.size()-1], -128);

    // Gapped input gives the same results as continuous
    do_reset();
    in_data = 8'd1;
    for (int i = 0; i < 48; i++) begin
      in_valid = (i % 2 == 0);
      cycle(1);
    end
    in_valid = 1'b0;
    cycle(ORDER + 4);
    check_dc_seq("gap");

    // Backpressure across two ticks, then clear
    do_reset();
    out_ready = 1'b0;
    run_held(1, 8);
    check("bp_count", got_a.size(), 2);
    check("bp_valid", va, 1);
    check("bp_data", da, 16);
    check("bp_overrun", ova, 1);
    clr_overrun = 1'b1;
    cycle(1);
    clr_overrun = 1'b0;
    cycle(1);
    check("clr_overrun", ova, 0);
    check("clr_keeps_valid", va, 1);
    check("clr_keeps_data", da, 16);

    // Clear held while a new overrun occurs: set wins
    clr_overrun = 1'b1;
    in_valid = 1'b1;
    cycle(4);
    in_valid = 1'b0;
    w = 0;
    while (w < 20 && got_a.size() < 3) begin
      @(negedge clk);
      #1;
      w++;
    end
    if (got_a.size() < 3) begin
      tests++;
      fails++;
      $display("FAIL set_wins_timeout: got %0d results, expected 3", got_a.size());
    end
    check("overrun_set_wins", ova, 1);
    clr_overrun = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    cycle(3);
    check("bp_drained", va, 0);

    // Ready pattern that collides with loads
    do_reset();
    in_data = 8'd3;
    in_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      out_ready = (i % 3 == 0);
      cycle(1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    cycle(ORDER + 4);
    check("pattern_count", got_a.size(), 15);
    if (got_a.size() > 0) check("pattern_last", got_a[got_a.size()-1], 48);

    // Reset one cycle after a tick discards the in-flight result
    do_reset();
    in_data = 8'd1;
    in_valid = 1'b1;
    cycle(8);
    in_valid = 1'b0;
    cycle(1);
    reset = 1'b1;
    cycle(2);
    reset = 1'b0;
    hi = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (va) hi++;
    end
    check("mid_reset_no_valid", hi, 0);
    @(posedge clk);
    #1;
    got_a.delete();
    got_b.delete();
    mod_a.delete();
    run_held(1, 8);
    check("post_reset_count", got_a.size(), 2);
    for (int k = 0; k < got_a.size(); k++) check("post_reset_a", got_a[k], (k == 0) ? 6 : 16);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
